atmega_tim_prescaler: RTL
=========================

Name: atmega_tim_prescaler

Overview:
- Shared prescaler and external-clock front end for the ATmega-compatible timer blocks. It sits directly upstream of atmega_tim_8bit and the 16-bit timers.
- Produces divided clock-level signals whose rising edges the timers detect, plus synchronized T-pin edge pulses for clock-select modes 6 and 7.
- Owns the GTCCR register (TSM, PSRASY, PSRSYNC) on the IO bus.

Parameters:
- BUS_ADDR_DATA_LEN, 8, width of addr_i.
- GTCCR_ADDR, 'h43, bus address of GTCCR.
- USE_ASYNC_PRESC, "TRUE", instantiate the second (timer2-style) prescaler; when "FALSE", all clk2_* outputs are tied to 0 and PSRASY reads 0.
- T_SYNC_STAGES, 2, synchronizer depth for t_i (minimum 2).

Ports:
- clk_i  in  1  IO core clock.
- rst_i  in  1  Asynchronous, active-high reset.
- addr_i  in  BUS_ADDR_DATA_LEN  IO bus address.
- wr_i  in  1  Write strobe.
- rd_i  in  1  Read strobe.
- bus_i  in  8  Write data.
- bus_o  out  8  Read data; combinational; 0 unless rd_i and addr_i==GTCCR_ADDR.
- clk8_o, clk64_o, clk256_o, clk1024_o  out  1 each  Sync prescaler taps.
- clk2_8_o, clk2_32_o, clk2_64_o, clk2_128_o, clk2_256_o, clk2_1024_o  out  1 each  Async-prescaler taps.
- t_i  in  1  External timer pin (asynchronous).
- t_rise_o  out  1  One-cycle pulse on a synchronized rising edge of t_i.
- t_fall_o  out  1  One-cycle pulse on a synchronized falling edge of t_i.

Behaviour:
- Reset (async assert, sync to clk_i in effect on the next edge):
  - both counters = 0; all clk* outputs = 0.
  - GTCCR = 0; synchronizer and previous-value flops = 0; t_rise_o = t_fall_o = 0.
- Sync prescaler: 10-bit up counter pcnt, +1 per clk_i, wraps 1023->0.
  - clk8_o=pcnt[2], clk64_o=pcnt[5], clk256_o=pcnt[7], clk1024_o=pcnt[9]; 50% duty, directly from flops.
  - After reset release, clk8_o first rises after edge 4, then every 8 edges.
  - clk1024_o first rises after edge 512, then every 1024 edges.
- Async prescaler: separate 10-bit counter acnt, same rules.
  - Taps: clk2_8=acnt[2], clk2_32=acnt[4], clk2_64=acnt[5], clk2_128=acnt[6], clk2_256=acnt[7], clk2_1024=acnt[9].
- GTCCR layout: bit7 TSM, bit1 PSRASY, bit0 PSRSYNC; bits 6:2 read 0, writes ignored.
  - Read value = {TSM,5'b0,PSRASY,PSRSYNC}.
- Write to GTCCR with bus_i[7]=0 (TSM cleared):
  - If bus_i[0]=1: pcnt <= 0 at that edge; PSRSYNC is not stored and reads 0.
  - If bus_i[1]=1: acnt <= 0 likewise.
  - All sync taps are 0 in the following cycle.
- Write with bus_i[7]=1 (TSM set):
  - TSM, PSRSYNC and PSRASY are stored from bus_i.
  - Any stored reset bit holds its counter at 0 every cycle; its taps stay 0.
- Writing TSM=0 clears PSRSYNC and PSRASY in the same edge. The held counters resume at the next edge (value 1 after that edge).
- While a counter is held, a write of 0 to its reset bit with TSM=1 releases that counter alone.
- Write and count on the same edge: the write-induced clear wins over the increment.
- T-pin path: t_i -> T_SYNC_STAGES flops (ts) -> t_prev.
  - t_rise_o = ts_last & ~t_prev; t_fall_o = ~ts_last & t_prev. Both are combinational from flops, glitch-free.
  - Latency with T_SYNC_STAGES=2: a t_i rise sampled at edge k gives t_rise_o high from edge k+1 to edge k+2 (one cycle).
  - Edges on consecutive samples each produce their pulse; a pulse is never wider than 1 cycle.
- Reset asserted mid-count or mid-hold: all state returns to reset values immediately (async). Counting restarts from 0 after release.

Test Plan:
- Reset release, free run 2048 cycles -> clk8_o rises at edges 4, 12, 20…; clk64_o period 64; clk1024_o rises at 512, 1536; clk2_32_o period 32.
- At pcnt=300, write GTCCR=0x01 -> pcnt=0 next cycle, all sync taps 0; GTCCR reads 0x00; acnt unaffected.
- Write 0x83 -> both counters held at 0 for 100 cycles; read 0x83. Write 0x00 -> counters read 1 after the next edge; clk8_o rises 4 edges after the release write.
- Toggle t_i high at cycle 10, low at cycle 20 (T_SYNC_STAGES=2) -> exactly one t_rise_o pulse, cycle 12; exactly one t_fall_o pulse, cycle 22.
- rd_i with addr_i≠GTCCR_ADDR -> bus_o=0x00. Write 0xFF -> reads 0x83. USE_ASYNC_PRESC="FALSE" -> reads 0x81 and clk2_* stay 0.
- Assert rst_i asynchronously mid-cycle at pcnt=700 -> clk256_o/clk1024_o drop without waiting for a clock edge; after release, the count sequence equals the post-reset sequence.

Source files
------------

// File: rtl/atmega_tim_prescaler.sv
// ---------------------------------------------------------------------------
// atmega_tim_prescaler
//
// Shared prescaler and external-clock front end for the ATmega-compatible
// timers (atmega_tim_8bit and the 16-bit timers sit directly downstream).
//
// The block contains:
//   - a 10-bit synchronous prescaler counter (pcnt) whose bits are exported
//     as 50% duty clock-level taps; the timers detect their rising edges,
//   - an optional second 10-bit prescaler (acnt, timer2 style) with its own
//     set of taps,
//   - the GTCCR register (TSM, PSRASY, PSRSYNC) on the IO bus,
//   - a synchronizer plus edge detector for the external T pin, used by the
//     timers in clock-select modes 6 (falling) and 7 (rising).
//
// Ports:
//   clk_i            IO core clock
//   rst_i            asynchronous, active-high reset
//   addr_i           IO bus address (BUS_ADDR_DATA_LEN bits)
//   wr_i / rd_i      IO bus write / read strobes
//   bus_i            write data
//   bus_o            read data, combinational, 0 unless reading GTCCR
//   clk8_o..clk1024_o          sync prescaler taps (pcnt[2], [5], [7], [9])
//   clk2_8_o..clk2_1024_o      async prescaler taps (acnt[2], [4], [5], [6],
//                              [7], [9]); tied 0 when the async prescaler
//                              is not built
//   t_i              external timer pin (asynchronous to clk_i)
//   t_rise_o         one-cycle pulse on a synchronized rising edge of t_i
//   t_fall_o         one-cycle pulse on a synchronized falling edge of t_i
//
// GTCCR read value is {TSM, 5'b0, PSRASY, PSRSYNC}.
//   TSM = 0 write : bits 0/1 act as one-shot counter clears and are not
//                   stored; the stored reset bits are cleared.
//   TSM = 1 write : TSM, PSRASY and PSRSYNC are stored; a stored reset bit
//                   holds its counter at 0 on every edge until it is
//                   cleared again.
// A write-induced clear always wins over the increment on the same edge.
// ---------------------------------------------------------------------------
module atmega_tim_prescaler #(
    parameter int                           BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR        = 'h43,
    parameter string                        USE_ASYNC_PRESC   = "TRUE",
    // Depth of the t_i synchronizer; must be at least 2.
    parameter int                           T_SYNC_STAGES     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_i,
    output logic [7:0]                   bus_o,

    output logic                         clk8_o,
    output logic                         clk64_o,
    output logic                         clk256_o,
    output logic                         clk1024_o,

    output logic                         clk2_8_o,
    output logic                         clk2_32_o,
    output logic                         clk2_64_o,
    output logic                         clk2_128_o,
    output logic                         clk2_256_o,
    output logic                         clk2_1024_o,

    input  logic                         t_i,
    output logic                         t_rise_o,
    output logic                         t_fall_o
);

    localparam bit ASYNC_EN = (USE_ASYNC_PRESC == "TRUE");

    // -----------------------------------------------------------------------
    // GTCCR register
    // -----------------------------------------------------------------------
    logic gtccr_wr;
    logic tsm_q;
    logic psrsync_q;
    logic psrasy_q;

    assign gtccr_wr = wr_i && (addr_i == GTCCR_ADDR);

    // GTCCR bits 6:2 always read as 0; write data on those bits is dropped.
    logic unused_bus_bits;
    assign unused_bus_bits = ^bus_i[6:2];

    // The reset bits are only stored while TSM is written as 1. Writing
    // TSM=0 therefore clears both stored bits on the same edge, which is
    // what releases any held counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tsm_q     <= 1'b0;
            psrsync_q <= 1'b0;
            psrasy_q  <= 1'b0;
        end else if (gtccr_wr) begin
            tsm_q     <= bus_i[7];
            psrsync_q <= bus_i[7] & bus_i[0];
            psrasy_q  <= ASYNC_EN & bus_i[7] & bus_i[1];
        end
    end

    assign bus_o = (rd_i && (addr_i == GTCCR_ADDR))
                 ? {tsm_q, 5'b00000, psrasy_q, psrsync_q}
                 : 8'h00;

    // -----------------------------------------------------------------------
    // Synchronous prescaler
    // -----------------------------------------------------------------------
    // The clear term uses the stored PSRSYNC as it was before this edge, so
    // on a releasing write the counter is still 0 after the write edge and
    // reaches 1 one edge later.
    logic       sync_clr;
    logic [9:0] pcnt;

    assign sync_clr = psrsync_q | (gtccr_wr & bus_i[0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt <= 10'd0;
        end else if (sync_clr) begin
            pcnt <= 10'd0;
        end else begin
            pcnt <= pcnt + 10'd1;
        end
    end

    // Taps come straight from counter flops, so they are glitch-free and
    // have exactly 50% duty.
    assign clk8_o    = pcnt[2];
    assign clk64_o   = pcnt[5];
    assign clk256_o  = pcnt[7];
    assign clk1024_o = pcnt[9];

    // -----------------------------------------------------------------------
    // Second (timer2 style) prescaler
    // -----------------------------------------------------------------------
    generate
        if (ASYNC_EN) begin : g_async
            logic       async_clr;
            logic [9:0] acnt;

            assign async_clr = psrasy_q | (gtccr_wr & bus_i[1]);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    acnt <= 10'd0;
                end else if (async_clr) begin
                    acnt <= 10'd0;
                end else begin
                    acnt <= acnt + 10'd1;
                end
            end

            assign clk2_8_o    = acnt[2];
            assign clk2_32_o   = acnt[4];
            assign clk2_64_o   = acnt[5];
            assign clk2_128_o  = acnt[6];
            assign clk2_256_o  = acnt[7];
            assign clk2_1024_o = acnt[9];
        end else begin : g_no_async
            assign clk2_8_o    = 1'b0;
            assign clk2_32_o   = 1'b0;
            assign clk2_64_o   = 1'b0;
            assign clk2_128_o  = 1'b0;
            assign clk2_256_o  = 1'b0;
            assign clk2_1024_o = 1'b0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // External T pin: synchronizer and edge detect
    // -----------------------------------------------------------------------
    // ts[0] is the first (metastability-catching) stage; ts[T_SYNC_STAGES-1]
    // is the settled value. t_prev holds the settled value one cycle older,
    // so each settled transition yields exactly one single-cycle pulse.
    logic [T_SYNC_STAGES-1:0] ts;
    logic                     t_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts     <= '0;
            t_prev <= 1'b0;
        end else begin
            ts     <= {ts[T_SYNC_STAGES-2:0], t_i};
            t_prev <= ts[T_SYNC_STAGES-1];
        end
    end

    assign t_rise_o =  ts[T_SYNC_STAGES-1] & ~t_prev;
    assign t_fall_o = ~ts[T_SYNC_STAGES-1] &  t_prev;

endmodule
